rom_programmer: RTL and testbench



---
 rtl/rom_programmer_pkg.sv | 35 +++
 rtl/rom_programmer_timer.sv | 29 ++
 rtl/rom_programmer.sv | 198 +++++++++++++++++++
 tb/tb_rom_programmer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_programmer_pkg.sv
// Shared definitions for the IP3601/IP3604 PROM programmer: chip-select
// encodings common with rom_reader, FSM state encoding and sizing helpers.
package rom_programmer_pkg;

    localparam logic [3:0] OP_DESELECT = 4'b1111;
    localparam logic [3:0] OP_READ     = 4'b1110;
    localparam logic [3:0] OP_PROGRAM  = 4'b1101;

    typedef enum logic [3:0] {
        ST_IDLE         = 4'd0,
        ST_SCAN         = 4'd1,
        ST_SETUP        = 4'd2,
        ST_PULSE        = 4'd3,
        ST_RECOVER      = 4'd4,
        ST_VERIFY_SETUP = 4'd5,
        ST_VERIFY       = 4'd6,
        ST_PASS         = 4'd7,
        ST_FAIL         = 4'd8
    } state_t;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    // Bits needed to hold N-1 for the longest timed state, never less than one.
    function automatic int timer_width(input int max_cycles);
        return ($clog2(max_cycles) < 1) ? 1 : $clog2(max_cycles);
    endfunction

endpackage

// File: rtl/rom_programmer_timer.sv
// Loadable down-counter shared by every timed programmer state; o_zero
// flags the final cycle of the state it is timing.
module prog_timer #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_value,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    // NOTE: sequential state always uses non-blocking assignments so every
    // register samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (r_count != '0) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/rom_programmer.sv
// Fuse-programming writer for IP3601/IP3604 bipolar PROMs: blows each requested
// bit with a timed pulse, read-verifies the word and retries a bounded number of times.
module rom_programmer
    import rom_programmer_pkg::*;
#(
    parameter int DATA_WIDTH      = 8,
    parameter int ADDRESS_WIDTH   = 9,
    parameter int SETUP_CYCLES    = 50,
    parameter int PULSE_CYCLES    = 1000,
    parameter int RECOVERY_CYCLES = 50,
    parameter int VERIFY_CYCLES   = 20,
    parameter int MAX_RETRIES     = 3
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] address_in,
    input  logic [DATA_WIDTH-1:0]    data_in,
    input  logic [DATA_WIDTH-1:0]    data_line_in,
    output logic [ADDRESS_WIDTH-1:0] address_line,
    output logic [3:0]               operation,
    output logic [DATA_WIDTH-1:0]    prog_bit_line,
    output logic                     prog_pulse,
    output logic                     busy,
    output logic                     done,
    output logic                     error
);

    localparam int CNT_W   = timer_width(max4(SETUP_CYCLES, PULSE_CYCLES,
                                              RECOVERY_CYCLES, VERIFY_CYCLES));
    localparam int RETRY_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

    localparam logic [CNT_W-1:0]   SETUP_LOAD    = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0]   PULSE_LOAD    = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   RECOVERY_LOAD = CNT_W'(RECOVERY_CYCLES - 1);
    localparam logic [CNT_W-1:0]   VERIFY_LOAD   = CNT_W'(VERIFY_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT   = RETRY_W'(MAX_RETRIES);

    state_t                   r_state;
    state_t                   w_next_state;
    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0]    r_data;
    logic [DATA_WIDTH-1:0]    r_pending;
    logic [DATA_WIDTH-1:0]    r_bit_sel;
    logic [RETRY_W-1:0]       r_retry;
    logic                     r_error;
    logic [DATA_WIDTH-1:0]    w_lowest;
    logic [DATA_WIDTH-1:0]    w_rd;
    logic                     w_load;
    logic [CNT_W-1:0]         w_load_value;
    logic                     w_zero;

    prog_timer #(.WIDTH(CNT_W)) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .i_load  (w_load),
        .i_value (w_load_value),
        .o_zero  (w_zero)
    );

    // Two's-complement trick isolates the lowest set bit, giving ascending order.
    assign w_lowest     = r_pending & (~r_pending + DATA_WIDTH'(1));
    assign w_rd         = data_line_in;
    assign address_line = r_addr;
    assign error        = r_error;

    // The pin outputs decode r_state directly, so the asynchronous reset
    // removes programming voltage and bit select without waiting for clk.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_next_state  = r_state;
        w_load        = 1'b0;
        w_load_value  = '0;
        operation     = OP_DESELECT;
        prog_bit_line = '0;
        prog_pulse    = 1'b0;
        busy          = (r_state != ST_IDLE);
        done          = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (data_in == '0) begin
                        w_next_state = ST_VERIFY_SETUP;
                        w_load       = 1'b1;
                        w_load_value = VERIFY_LOAD;
                    end else begin
                        w_next_state = ST_SCAN;
                    end
                end
            end
            ST_SCAN: begin
                w_load = 1'b1;
                if (r_pending != '0) begin
                    w_next_state = ST_SETUP;
                    w_load_value = SETUP_LOAD;
                end else begin
                    w_next_state = ST_VERIFY_SETUP;
                    w_load_value = VERIFY_LOAD;
                end
            end
            ST_SETUP: begin
                operation     = OP_PROGRAM;
                prog_bit_line = r_bit_sel;
                if (w_zero) begin
                    w_next_state = ST_PULSE;
                    w_load       = 1'b1;
                    w_load_value = PULSE_LOAD;
                end
            end
            ST_PULSE: begin
                operation     = OP_PROGRAM;
                prog_bit_line = r_bit_sel;
                prog_pulse    = 1'b1;
                if (w_zero) begin
                    w_next_state = ST_RECOVER;
                    w_load       = 1'b1;
                    w_load_value = RECOVERY_LOAD;
                end
            end
            ST_RECOVER: begin
                operation     = OP_PROGRAM;
                prog_bit_line = r_bit_sel;
                if (w_zero) w_next_state = ST_SCAN;
            end
            ST_VERIFY_SETUP: begin
                operation = OP_READ;
                if (w_zero) w_next_state = ST_VERIFY;
            end
            ST_VERIFY: begin
                operation = OP_READ;
                // A blown fuse outside the target word can never be undone.
                if ((w_rd & ~r_data) != '0)  w_next_state = ST_FAIL;
                else if (w_rd == r_data)     w_next_state = ST_PASS;
                else if (r_retry < RETRY_LIMIT) w_next_state = ST_SCAN;
                else                         w_next_state = ST_FAIL;
            end
            ST_PASS: begin
                done         = 1'b1;
                w_next_state = ST_IDLE;
            end
            ST_FAIL: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr    <= '0;
            r_data    <= '0;
            r_pending <= '0;
            r_bit_sel <= '0;
            r_retry   <= '0;
            r_error   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_addr    <= address_in;
                        r_data    <= data_in;
                        r_pending <= data_in;
                        r_retry   <= '0;
                        r_error   <= 1'b0;
                    end
                end
                ST_SCAN: begin
                    if (r_pending != '0) r_bit_sel <= w_lowest;
                end
                ST_RECOVER: begin
                    if (w_zero) r_pending <= r_pending & ~r_bit_sel;
                end
                ST_VERIFY: begin
                    if (w_next_state == ST_SCAN) begin
                        r_retry   <= r_retry + RETRY_W'(1);
                        r_pending <= r_data & ~w_rd;
                    end
                    if (w_next_state == ST_FAIL) r_error <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_programmer.sv
// Self-checking bench for rom_programmer with a fuse-blowing PROM model,
// a pulse scoreboard and a table of programming scenarios.
module tb_rom_programmer;

    localparam logic [3:0] OP_DESELECT = 4'b1111;
    localparam logic [3:0] OP_READ     = 4'b1110;
    localparam logic [3:0] OP_PROGRAM  = 4'b1101;
    localparam int         BUDGET      = 2000;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic [7:0] address_in;
    logic [3:0] data_in;
    logic [3:0] data_line_in;
    logic [7:0] address_line;
    logic [3:0] operation;
    logic [3:0] prog_bit_line;
    logic       prog_pulse;
    logic       busy;
    logic       done;
    logic       error;

    rom_programmer #(
        .DATA_WIDTH      (4),
        .ADDRESS_WIDTH   (8),
        .SETUP_CYCLES    (2),
        .PULSE_CYCLES    (2),
        .RECOVERY_CYCLES (2),
        .VERIFY_CYCLES   (2),
        .MAX_RETRIES     (3)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .address_in    (address_in),
        .data_in       (data_in),
        .data_line_in  (data_line_in),
        .address_line  (address_line),
        .operation     (operation),
        .prog_bit_line (prog_bit_line),
        .prog_pulse    (prog_pulse),
        .busy          (busy),
        .done          (done),
        .error         (error)
    );

    typedef struct {
        logic [7:0]  addr;
        logic [3:0]  data;
        logic [3:0]  pre;      // fuses already blown before the run
        logic [3:0]  ign;      // bits whose first pulse does not take
        logic [3:0]  never_m;  // bits that can never be blown
        logic [31:0] seq;      // expected pulse bits, one nibble per pulse, first in bits 3:0
        int          npulse;
        int          exp_done;
        logic        exp_err;
        logic [3:0]  exp_mem;
        int          exp_lat;  // cycle of done counting the start cycle as 1; 0 = unchecked
    } vec_t;

    int         n_checks = 0;
    int         n_errors = 0;
    int         n_pulses = 0;
    logic [3:0] mem [256] = '{default: 4'h0};
    logic [3:0] exp_q [$];
    vec_t       res_q [$];
    vec_t       vecs [10];

    logic [7:0] cur_addr = 8'h00;
    logic [3:0] never_mask = 4'h0;
    logic [7:0] pre_addr = 8'h00;
    logic [3:0] pre_val = 4'h0;
    logic [3:0] pre_ign = 4'h0;
    int         pre_seq = 0;

    assign data_line_in = (operation == OP_READ) ? mem[address_line] : 4'h0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Chip model and pulse scoreboard: fuses blow on the rising pulse edge,
    // each finished pulse is compared against the expected bit queue.
    int         pre_seen = 0;
    logic [3:0] ign_left = 4'h0;
    logic       in_pulse = 1'b0;
    int         width = 0;
    logic [3:0] pulse_bits = 4'h0;
    always @(negedge clk) begin
        if (pre_seq != pre_seen) begin
            mem[pre_addr] = pre_val;
            ign_left      = pre_ign;
            pre_seen      = pre_seq;
        end
        if (!reset_n) begin
            in_pulse = 1'b0;
        end else if (prog_pulse) begin
            if (!in_pulse) begin
                in_pulse   = 1'b1;
                width      = 1;
                pulse_bits = prog_bit_line;
                n_pulses++;
                check("pulse_operation", 32'(operation), 32'(OP_PROGRAM));
                check("pulse_address", 32'(address_line), 32'(cur_addr));
                if (operation == OP_PROGRAM) begin
                    if ((ign_left & prog_bit_line) != 4'h0)
                        ign_left = ign_left & ~prog_bit_line;
                    else
                        mem[address_line] = mem[address_line] | (prog_bit_line & ~never_mask);
                end
            end else begin
                width++;
            end
        end else if (in_pulse) begin
            in_pulse = 1'b0;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_pulse: got pulse on bits 0x%0h required no pulse", pulse_bits);
            end else begin
                check("pulse_bit", 32'(pulse_bits), 32'(exp_q.pop_front()));
                check("pulse_width", 32'(width), 32'd2);
            end
        end
    end

    task automatic preset(input logic [7:0] a, input logic [3:0] v, input logic [3:0] ign,
                          input logic [3:0] nv);
        pre_addr   = a;
        pre_val    = v;
        pre_ign    = ign;
        never_mask = nv;
        pre_seq++;
    endtask

    task automatic run_vec(input string tag, input vec_t v, input int inject_at);
        int   lat;
        int   done_cnt;
        int   done_lat;
        int   start_pulses;
        bit   finished;
        vec_t r;
        preset(v.addr, v.pre, v.ign, v.never_m);
        @(negedge clk);
        address_in = v.addr;
        data_in    = v.data;
        start      = 1'b1;
        cur_addr   = v.addr;
        start_pulses = n_pulses;
        for (int i = 0; i < v.npulse; i++) exp_q.push_back(v.seq[4*i +: 4]);
        res_q.push_back(v);
        @(negedge clk);
        start = 1'b0;
        lat = 2;
        check({tag, "_busy_after_start"}, 32'(busy), 32'd1);
        check({tag, "_error_cleared"}, 32'(error), 32'd0);
        done_cnt = 0;
        done_lat = 0;
        finished = 1'b0;
        for (int c = 0; c < BUDGET; c++) begin
            if (done) begin
                done_cnt++;
                done_lat = lat;
            end
            if (!busy) begin
                finished = 1'b1;
                break;
            end
            @(negedge clk);
            lat++;
            if (lat == inject_at) begin
                address_in = 8'h31;
                data_in    = 4'hF;
                start      = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        r = res_q.pop_front();
        check({tag, "_finished"}, 32'(finished), 32'd1);
        check({tag, "_done_count"}, 32'(done_cnt), 32'(r.exp_done));
        check({tag, "_error"}, 32'(error), 32'(r.exp_err));
        check({tag, "_mem"}, 32'(mem[r.addr]), 32'(r.exp_mem));
        check({tag, "_pulse_count"}, 32'(n_pulses - start_pulses), 32'(r.npulse));
        if (r.exp_lat != 0) check({tag, "_latency"}, 32'(done_lat), 32'(r.exp_lat));
        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_missing_pulses: got %0d pulses short required 0", tag, exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
        check({tag, "_error_sticky"}, 32'(error), 32'(r.exp_err));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_address_line"}, 32'(address_line), 32'h0);
        check({tag, "_operation"}, 32'(operation), 32'(OP_DESELECT));
        check({tag, "_prog_bit_line"}, 32'(prog_bit_line), 32'h0);
        check({tag, "_prog_pulse"}, 32'(prog_pulse), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_done"}, 32'(done), 32'h0);
        check({tag, "_error"}, 32'(error), 32'h0);
    endtask

    initial begin
        vec_t v;
        bit   seen;
        //          addr   data  pre   ign   never seq            n  done err  mem   lat
        vecs[0] = '{8'h2A, 4'h5, 4'h0, 4'h0, 4'h0, 32'h00000041, 2, 1, 1'b0, 4'h5, 20};
        vecs[1] = '{8'h10, 4'h0, 4'h0, 4'h0, 4'h0, 32'h00000000, 0, 1, 1'b0, 4'h0, 5};
        vecs[2] = '{8'h11, 4'h2, 4'h0, 4'h2, 4'h0, 32'h00000022, 2, 1, 1'b0, 4'h2, 24};
        vecs[3] = '{8'h12, 4'h8, 4'h0, 4'h0, 4'h8, 32'h00008888, 4, 0, 1'b1, 4'h0, 0};
        vecs[4] = '{8'h13, 4'h2, 4'h1, 4'h0, 4'h0, 32'h00000002, 1, 0, 1'b1, 4'h3, 0};
        vecs[5] = '{8'h14, 4'hF, 4'h0, 4'h0, 4'h0, 32'h00008421, 4, 1, 1'b0, 4'hF, 34};
        vecs[6] = '{8'hFF, 4'hA, 4'h0, 4'h0, 4'h0, 32'h00000082, 2, 1, 1'b0, 4'hA, 20};
        vecs[7] = '{8'h00, 4'h7, 4'h0, 4'h5, 4'h0, 32'h00041421, 5, 1, 1'b0, 4'h7, 45};
        vecs[8] = '{8'h15, 4'h1, 4'h0, 4'h0, 4'h1, 32'h00001111, 4, 0, 1'b1, 4'h0, 0};
        vecs[9] = '{8'h16, 4'h5, 4'h5, 4'h0, 4'h0, 32'h00000041, 2, 1, 1'b0, 4'h5, 20};

        reset_n    = 1'b1;
        start      = 1'b0;
        address_in = 8'h00;
        data_in    = 4'h0;
        #2 reset_n = 1'b0;
        @(negedge clk);
        check_reset_values("reset");
        @(negedge clk);
        #2 reset_n = 1'b1;

        for (int i = 0; i < 10; i++) run_vec($sformatf("vec%0d", i), vecs[i], 0);

        // A second start while busy must neither restart nor relatch.
        v = '{8'h30, 4'h1, 4'h0, 4'h0, 4'h0, 32'h00000001, 1, 1, 1'b0, 4'h1, 13};
        run_vec("busy_start", v, 4);
        check("busy_start_other_addr", 32'(mem[8'h31]), 32'h0);

        // Reset during the second cycle of the programming pulse.
        preset(8'h40, 4'h0, 4'h0, 4'h0);
        @(negedge clk);
        address_in = 8'h40;
        data_in    = 4'h4;
        start      = 1'b1;
        cur_addr   = 8'h40;
        @(negedge clk);
        start = 1'b0;
        seen  = 1'b0;
        for (int c = 0; c < BUDGET; c++) begin
            if (prog_pulse) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("reset_test_pulse_seen", 32'(seen), 32'd1);
        @(posedge clk);
        #2;
        check("reset_test_pulse_before", 32'(prog_pulse), 32'd1);
        reset_n = 1'b0;
        #1;
        check_reset_values("mid_pulse_reset");
        @(negedge clk);
        @(negedge clk);
        #2 reset_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (busy || prog_pulse) seen = 1'b1;
        end
        check("no_resume_after_reset", 32'(seen), 32'd0);

        v = '{8'h41, 4'h3, 4'h0, 4'h0, 4'h0, 32'h00000021, 2, 1, 1'b0, 4'h3, 20};
        run_vec("post_reset", v, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
